reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register and data-port width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning register-index width; NUM_REGS = 2**ADDR_W.
REQ-003 The block SHALL have parameter BYPASS, default 1, meaning same-cycle write-to-read forwarding enabled (1) or disabled (0).
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-006 The block SHALL have port RegWrite, input, 1, write enable from control.
REQ-007 The block SHALL have port WriteReg, input, ADDR_W, destination index (output of the RegDst destination mux).
REQ-008 The block SHALL have port WriteData, input, DATA_W, write-back value.
REQ-009 The block SHALL have port ReadReg1, input, ADDR_W, source index rs (inst[25:21]).
REQ-010 The block SHALL have port ReadReg2, input, ADDR_W, source index rt (inst[20:16]).
REQ-011 The block SHALL have port ReadData1, output, DATA_W, contents of ReadReg1.
REQ-012 The block SHALL have port ReadData2, output, DATA_W, contents of ReadReg2.
REQ-013 The block SHALL have port ready, output, 1, high once initialisation is complete; the CPU stalls PC update while low.

Function
REQ-014 The block SHALL implement a two-state FSM: INIT, RUN.
REQ-015 In INIT, the block SHALL clear one register per cycle via init counter idx, 0..NUM_REGS-1, ascending.
REQ-016 When idx = NUM_REGS-1 is cleared, the FSM SHALL go INIT->RUN; ready SHALL rise on that same edge, i.e. exactly NUM_REGS (32) rising edges after rst_n deassertion.
REQ-017 RUN SHALL be terminal until the next reset.
REQ-018 In INIT, RegWrite SHALL be ignored, and ReadData1/ReadData2 SHALL be 0.
REQ-019 In RUN, reads SHALL be combinational (zero latency): ReadDataN = reg[ReadRegN].
REQ-020 Index 0 SHALL always read as 0 regardless of any write; writes to index 0 SHALL be discarded.
REQ-021 In RUN, a write SHALL occur on the rising edge when RegWrite=1 and WriteReg!=0; the new value is visible to reads from the following cycle.
REQ-022 If BYPASS=1, RUN, RegWrite=1, WriteReg!=0 and WriteReg=ReadRegN, then ReadDataN SHALL equal WriteData in the same cycle.
REQ-023 Both read ports addressing the same register SHALL return identical values, including under bypass.
REQ-024 With RegWrite=0, registers SHALL hold their value indefinitely.
REQ-025 The block SHALL perform no arithmetic on data; idx SHALL stop at NUM_REGS-1 and never wrap.

Reset
REQ-026 Asserting rst_n low SHALL immediately force state=INIT, idx=0, ready=0, and ReadData1/ReadData2=0, independent of clk.
REQ-027 Reset asserted mid-INIT or mid-RUN SHALL abort any in-flight write, and SHALL restart the full 32-cycle clear after deassertion.
REQ-028 The register array itself SHALL NOT be asynchronously reset; it SHALL be cleared only by the INIT sweep.

Structure
REQ-029 DATA_W, ADDR_W and NUM_REGS defaults, plus the INIT/RUN state encoding, SHALL live in the shared package mips_pkg.
REQ-030 The FSM and counter SHALL be a sub-module reg_file_init_fsm (outputs: init_en, init_idx, ready); reg_file SHALL hold the array, read muxes and bypass.

Verification
REQ-031 Reset then 32 clocks: ready=0 through cycle 31 and =1 after edge 32; every index reads 0.
REQ-032 RUN, write 0xDEADBEEF to r8, then read r8 on both ports: 0xDEADBEEF on each next cycle.
REQ-033 RUN, write 0x12345678 to r0, then read r0: result 0.
REQ-034 BYPASS=1: r9=0x1 held, same cycle RegWrite r9=0xA5A5A5A5 and ReadReg1=9: ReadData1=0xA5A5A5A5 that cycle. BYPASS=0: ReadData1=0x1 that cycle, 0xA5A5A5A5 next.
REQ-035 Write r5=0x55 at INIT cycle 10: ignored; after ready, r5 reads 0.
REQ-036 RUN with r3=0x33, rst_n pulsed low mid-cycle: outputs 0 and ready=0 immediately; after 32 clocks ready=1 and r3 reads 0.

Source files
------------

// File: rtl/mips_pkg.sv
`timescale 1ns/1ps
// mips_pkg
// Purpose : Shared definitions for the MIPS datapath blocks. Holds the
//           default register-file geometry and the state encoding of the
//           register-file initialisation FSM.
// Contents: RF_DATA_W / RF_ADDR_W / RF_NUM_REGS defaults, rf_state_e.
package mips_pkg;

  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_NUM_REGS = 2 ** RF_ADDR_W;

  // INIT sweeps the array to zero after reset; RUN is normal operation.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } rf_state_e;

endpackage : mips_pkg

// File: rtl/reg_file_if.sv
`timescale 1ns/1ps
// reg_file_if
// Purpose : Bundles the register-file bus between the datapath (master)
//           and the register file (slave).
// Signals : RegWrite, WriteReg, WriteData    - write port (master -> slave)
//           ReadReg1, ReadReg2                - read indices (master -> slave)
//           ReadData1, ReadData2              - read data (slave -> master)
//           ready                             - initialisation done (slave -> master)
interface reg_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) ();

  logic              RegWrite;
  logic [ADDR_W-1:0] WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic [ADDR_W-1:0] ReadReg1;
  logic [ADDR_W-1:0] ReadReg2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic              ready;

  modport master (
    output RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2,
    input  ReadData1, ReadData2, ready
  );

  modport slave (
    input  RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2,
    output ReadData1, ReadData2, ready
  );

endinterface : reg_file_if

// File: rtl/reg_file_init_fsm.sv
`timescale 1ns/1ps
// reg_file_init_fsm
// Purpose : After reset, walks an index 0..NUM_REGS-1 (one per clock) so the
//           register file can clear its array, then raises ready and stays
//           in RUN until the next reset.
// Ports   : clk      - clock
//           rst_n    - asynchronous active-low reset
//           init_en  - high while the clear sweep is in progress
//           init_idx - register index being cleared this cycle
//           ready    - high once every register has been cleared
module reg_file_init_fsm
  import mips_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              init_en,
  output logic [ADDR_W-1:0] init_idx,
  output logic              ready
);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  rf_state_e         state_q;
  logic [ADDR_W-1:0] idx_q;
  logic              init_en_q;
  logic              ready_q;

  // The index saturates at LAST_IDX: the clear of the last register and
  // the INIT->RUN transition happen on the same edge, so ready rises
  // exactly NUM_REGS edges after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      idx_q     <= '0;
      init_en_q <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (idx_q == LAST_IDX) begin
            state_q   <= ST_RUN;
            init_en_q <= 1'b0;
            ready_q   <= 1'b1;
          end else begin
            idx_q <= idx_q + ADDR_W'(1);
          end
        end
        ST_RUN: begin
          state_q   <= ST_RUN;
          init_en_q <= 1'b0;
          ready_q   <= 1'b1;
        end
        default: begin
          state_q   <= ST_INIT;
          idx_q     <= '0;
          init_en_q <= 1'b1;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  assign init_en  = init_en_q;
  assign init_idx = idx_q;
  assign ready    = ready_q;

endmodule : reg_file_init_fsm

// File: rtl/reg_file.sv
`timescale 1ns/1ps
// reg_file
// Purpose : MIPS general-purpose register file: NUM_REGS x DATA_W array,
//           two combinational read ports, one synchronous write port,
//           r0 hard-wired to zero, optional same-cycle write->read
//           forwarding. The array has no reset; it is zeroed by a
//           one-register-per-cycle sweep after reset.
// Ports   : clk   - clock
//           rst_n - asynchronous active-low reset (control path only)
//           bus   - reg_file_if.slave (write port, read ports, ready)
module reg_file
  import mips_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter bit BYPASS = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  reg_file_if.slave  bus
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic              init_en;
  logic [ADDR_W-1:0] init_idx;
  logic              ready;

  reg_file_init_fsm #(
    .ADDR_W (ADDR_W)
  ) u_init_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .init_en  (init_en),
    .init_idx (init_idx),
    .ready    (ready)
  );

  // Register array: plain storage, no reset.
  logic [DATA_W-1:0] regs_q [NUM_REGS];

  // A user write counts only in RUN and never targets r0. Because ready is
  // cleared asynchronously, asserting reset also kills any pending write.
  logic              user_we;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_idx;
  logic [DATA_W-1:0] wr_data;

  assign user_we = ready && bus.RegWrite && (bus.WriteReg != '0);
  assign wr_en   = init_en || user_we;
  assign wr_idx  = init_en ? init_idx : bus.WriteReg;
  assign wr_data = init_en ? '0       : bus.WriteData;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      regs_q[wr_idx] <= wr_data;
    end
  end

  // Both read ports share one decode so they always agree for the same index.
  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];

  assign rd_addr[0] = bus.ReadReg1;
  assign rd_addr[1] = bus.ReadReg2;

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
    logic fwd_hit;
    assign fwd_hit = BYPASS && user_we && (bus.WriteReg == rd_addr[gi]);
    assign rd_data[gi] = (!ready || rd_addr[gi] == '0) ? '0 :
                         fwd_hit                       ? bus.WriteData :
                                                         regs_q[rd_addr[gi]];
  end

  assign bus.ReadData1 = rd_data[0];
  assign bus.ReadData2 = rd_data[1];
  assign bus.ready     = ready;

endmodule : reg_file

// File: tb/tb_reg_file.sv
`timescale 1ns/1ps
// tb_reg_file
// Purpose : Directed self-checking bench for reg_file. Two instances share
//           one stimulus stream: dut_b (forwarding on) and dut_n
//           (forwarding off). Expected values are queued when stimulus is
//           applied and popped when the outputs are sampled.
module tb_reg_file;
  import mips_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_file_if #(.DATA_W(32), .ADDR_W(5)) bus_b ();
  reg_file_if #(.DATA_W(32), .ADDR_W(5)) bus_n ();

  reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut_n (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_n)
  );

  assign bus_n.RegWrite  = bus_b.RegWrite;
  assign bus_n.WriteReg  = bus_b.WriteReg;
  assign bus_n.WriteData = bus_b.WriteData;
  assign bus_n.ReadReg1  = bus_b.ReadReg1;
  assign bus_n.ReadReg2  = bus_b.ReadReg2;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] sb_q[$];

  task automatic expect_val(input logic [31:0] e);
    sb_q.push_back(e);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard empty, observed=%h", tag, obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  task automatic drive(input logic rw, input logic [4:0] wreg,
                       input logic [31:0] wdata,
                       input logic [4:0] r1, input logic [4:0] r2);
    bus_b.RegWrite  = rw;
    bus_b.WriteReg  = wreg;
    bus_b.WriteData = wdata;
    bus_b.ReadReg1  = r1;
    bus_b.ReadReg2  = r2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    rst_n = 1'b0;
    #12;
    expect_val(32'h0); check("reset_ready", {31'b0, bus_b.ready});
    expect_val(32'h0); check("reset_rd1",   bus_b.ReadData1);

    // Release reset, count edges up to ready.
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (k == 10) drive(1'b1, 5'd5, 32'h55, 5'd5, 5'd5);
      if (k == 11) drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      #2;
      expect_val({31'b0, (k >= 32)}); check($sformatf("init_ready_k%0d", k), {31'b0, bus_b.ready});
      expect_val({31'b0, (k >= 32)}); check($sformatf("init_ready_n_k%0d", k), {31'b0, bus_n.ready});
      if (k == 10) begin
        expect_val(32'h0); check("init_write_rd1", bus_b.ReadData1);
      end
    end

    // Every index reads zero after the sweep (r5 write was ignored).
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      #2;
      expect_val(32'h0); check($sformatf("clr_rd1_r%0d", i), bus_b.ReadData1);
      expect_val(32'h0); check($sformatf("clr_rd2_r%0d", 31 - i), bus_b.ReadData2);
    end

    // Write r8, read both ports next cycle.
    @(negedge clk); drive(1'b1, 5'd8, 32'hDEADBEEF, 5'd0, 5'd0);
    #2; expect_val(32'h0); check("w8_rd_r0", bus_b.ReadData1);
    @(negedge clk); drive(1'b0, 5'd0, 32'h0, 5'd8, 5'd8);
    #2;
    expect_val(32'hDEADBEEF); check("r8_rd1",   bus_b.ReadData1);
    expect_val(32'hDEADBEEF); check("r8_rd2",   bus_b.ReadData2);
    expect_val(32'hDEADBEEF); check("r8_n_rd1", bus_n.ReadData1);

    // Write to r0 is discarded, also not forwarded.
    @(negedge clk); drive(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0);
    #2; expect_val(32'h0); check("r0_fwd_rd1", bus_b.ReadData1);
    @(negedge clk); drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    #2;
    expect_val(32'h0); check("r0_rd1", bus_b.ReadData1);
    expect_val(32'h0); check("r0_rd2", bus_b.ReadData2);

    // Forwarding: r9 holds 1, rewritten with A5A5A5A5 while being read.
    @(negedge clk); drive(1'b1, 5'd9, 32'h1, 5'd0, 5'd0);
    @(negedge clk); drive(1'b1, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd9);
    #2;
    expect_val(32'hA5A5A5A5); check("byp_rd1",   bus_b.ReadData1);
    expect_val(32'hA5A5A5A5); check("byp_rd2",   bus_b.ReadData2);
    expect_val(32'h1);        check("nobyp_rd1", bus_n.ReadData1);
    expect_val(32'h1);        check("nobyp_rd2", bus_n.ReadData2);
    @(negedge clk); drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
    #2;
    expect_val(32'hA5A5A5A5); check("byp_next_rd1",   bus_b.ReadData1);
    expect_val(32'hA5A5A5A5); check("nobyp_next_rd1", bus_n.ReadData1);

    // Top index, then hold with RegWrite low and noisy write inputs.
    @(negedge clk); drive(1'b1, 5'd31, 32'hFFFF0000, 5'd0, 5'd0);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk); drive(1'b0, 5'd8, $urandom, 5'd0, 5'd0);
    end
    @(negedge clk); drive(1'b0, 5'd31, 32'h0BADF00D, 5'd31, 5'd8);
    #2;
    expect_val(32'hFFFF0000); check("r31_rd1",  bus_b.ReadData1);
    expect_val(32'hDEADBEEF); check("hold_r8",  bus_b.ReadData2);
    expect_val(32'hFFFF0000); check("r31_n_rd1", bus_n.ReadData1);

    // Reset mid-RUN: r3=0x33, then reset while a write to r3 is pending.
    @(negedge clk); drive(1'b1, 5'd3, 32'h33, 5'd0, 5'd0);
    @(negedge clk); drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    #2; expect_val(32'h33); check("r3_pre_rst", bus_b.ReadData1);
    #1;
    drive(1'b1, 5'd3, 32'h77, 5'd3, 5'd3);
    rst_n = 1'b0;
    #1;
    expect_val(32'h0); check("rst_ready",   {31'b0, bus_b.ready});
    expect_val(32'h0); check("rst_n_ready", {31'b0, bus_n.ready});
    expect_val(32'h0); check("rst_rd1",     bus_b.ReadData1);
    expect_val(32'h0); check("rst_rd2",     bus_b.ReadData2);
    expect_val(32'h0); check("rst_n_rd1",   bus_n.ReadData1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      #2;
      expect_val({31'b0, (k >= 32)}); check($sformatf("rerun_ready_k%0d", k), {31'b0, bus_b.ready});
    end
    expect_val(32'h1); check("rerun_n_ready", {31'b0, bus_n.ready});
    expect_val(32'h0); check("rerun_r3_rd1",  bus_b.ReadData1);
    expect_val(32'h0); check("rerun_r3_rd2",  bus_b.ReadData2);
    expect_val(32'h0); check("rerun_r3_n",    bus_n.ReadData1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_reg_file
